xyz_stim_seq: RTL and testbench

XYZ_STIM_SEQ -- requirements
Module: xyz_stim_seq

---
 rtl/xyz_stim_seq.sv | 171 +++++++++++++++++
 tb/tb_xyz_stim_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/xyz_stim_seq.sv
// Three-bit stimulus sequencer: steps {x,y,z} through binary, Gray or
// walking-one patterns, holding each vector hold_cycles+1 clocks.
module xyz_stim_seq #(
  parameter int HOLD_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              loop,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              x,
  output logic              y,
  output logic              z,
  output logic [2:0]        vec_idx,
  output logic              busy,
  output logic              done,
  output logic              any_hi
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

  state_t            state, state_nx;
  logic [1:0]        mode_q, mode_nx;
  logic              loop_q, loop_nx;
  logic [HOLD_W-1:0] hold_q, hold_nx;
  logic [HOLD_W-1:0] cnt, cnt_nx;
  logic [2:0]        xyz_nx, vec_nx;
  logic              busy_nx, done_nx;
  logic [2:0]        last_idx;
  logic              at_last, expire, go;

  // mode 11 falls through to binary so the output is always defined
  function automatic logic [2:0] pattern(input logic [1:0] m, input logic [2:0] i);
    logic [2:0] p;
    case (m)
      2'b01: p = i ^ (i >> 1);
      2'b10: begin
        case (i)
          3'd0:    p = 3'b100;
          3'd1:    p = 3'b010;
          3'd2:    p = 3'b001;
          default: p = 3'b000;
        endcase
      end
      default: p = i;
    endcase
    return p;
  endfunction

  assign last_idx = (mode_q == 2'b10) ? 3'd2 : 3'd7;
  assign at_last  = (vec_idx == last_idx);
  assign expire   = (cnt == '0);
  assign go       = start && !abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (go) state_nx = LOAD;
      LOAD: state_nx = abort ? IDLE : HOLD;
      HOLD: begin
        if (abort)                            state_nx = IDLE;
        else if (expire && at_last && !loop_q) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for every registered output, counter and latched config.
  always_comb begin
    xyz_nx  = {x, y, z};
    vec_nx  = vec_idx;
    cnt_nx  = cnt;
    busy_nx = busy;
    done_nx = 1'b0;
    mode_nx = mode_q;
    loop_nx = loop_q;
    hold_nx = hold_q;
    case (state)
      IDLE: begin
        xyz_nx  = 3'b000;
        vec_nx  = 3'd0;
        busy_nx = 1'b0;
        if (go) begin
          mode_nx = mode;
          loop_nx = loop;
          hold_nx = hold_cycles;
          busy_nx = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          xyz_nx  = 3'b000;
          vec_nx  = 3'd0;
          cnt_nx  = '0;
          busy_nx = 1'b0;
        end else begin
          xyz_nx  = pattern(mode_q, 3'd0);
          vec_nx  = 3'd0;
          cnt_nx  = hold_q;
          busy_nx = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          xyz_nx  = 3'b000;
          vec_nx  = 3'd0;
          cnt_nx  = '0;
          busy_nx = 1'b0;
        end else if (!expire) begin
          cnt_nx = cnt - HOLD_W'(1);
        end else if (!at_last) begin
          vec_nx = vec_idx + 3'd1;
          xyz_nx = pattern(mode_q, vec_idx + 3'd1);
          cnt_nx = hold_q;
        end else if (loop_q) begin
          vec_nx = 3'd0;
          xyz_nx = pattern(mode_q, 3'd0);
          cnt_nx = hold_q;
        end else begin
          xyz_nx  = 3'b000;
          vec_nx  = 3'd0;
          busy_nx = 1'b0;
          done_nx = 1'b1;
        end
      end
      DONE: begin
        xyz_nx  = 3'b000;
        vec_nx  = 3'd0;
        busy_nx = 1'b0;
      end
      default: begin
        xyz_nx  = 3'b000;
        vec_nx  = 3'd0;
        busy_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {x, y, z} <= 3'b000;
      vec_idx   <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      any_hi    <= 1'b0;
      cnt       <= '0;
      mode_q    <= 2'b00;
      loop_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      {x, y, z} <= xyz_nx;
      vec_idx   <= vec_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      any_hi    <= x | y | z;
      cnt       <= cnt_nx;
      mode_q    <= mode_nx;
      loop_q    <= loop_nx;
      hold_q    <= hold_nx;
    end
  end

endmodule

// File: tb/tb_xyz_stim_seq.sv
// Directed bench for xyz_stim_seq; expected vectors are hand tables,
// outputs sampled on the falling clock edge.
module tb_xyz_stim_seq;

  logic       clock = 1'b0;
  logic       reset_n, start, abort, loop;
  logic [1:0] mode;
  logic [3:0] hold_cycles;
  logic       x, y, z, busy, done, any_hi;
  logic [2:0] vec_idx;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_prev = 3'b000;
  logic [2:0] obs_prev;

  logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [2:0] walk_tab [3] = '{3'b100, 3'b010, 3'b001};

  xyz_stim_seq #(.HOLD_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .mode(mode), .loop(loop), .hold_cycles(hold_cycles),
    .x(x), .y(y), .z(z), .vec_idx(vec_idx),
    .busy(busy), .done(done), .any_hi(any_hi)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One clock: check all outputs against expectations; any_hi lags xyz by one cycle.
  task automatic cyc(input string tag, input logic [2:0] e_xyz, input logic [2:0] e_vec,
                     input logic e_busy, input logic e_done);
    @(negedge clock);
    chk({tag, ".xyz"},  {29'd0, x, y, z}, {29'd0, e_xyz});
    chk({tag, ".vec"},  {29'd0, vec_idx}, {29'd0, e_vec});
    chk({tag, ".busy"}, {31'd0, busy},    {31'd0, e_busy});
    chk({tag, ".done"}, {31'd0, done},    {31'd0, e_done});
    chk({tag, ".any"},  {31'd0, any_hi},  {31'd0, |exp_prev});
    exp_prev = e_xyz;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    mode = 2'b00; hold_cycles = 4'd0;
    repeat (2) @(negedge clock);
    chk("rst.xyz",  {29'd0, x, y, z}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.any",  {31'd0, any_hi}, 32'd0);
    reset_n = 1'b1;
    repeat (2) cyc("idle", 3'b000, 3'd0, 1'b0, 1'b0);

    // binary, single pass, one cycle per vector; start toggled mid-run with other config
    mode = 2'b00; loop = 1'b0; hold_cycles = 4'd0; start = 1'b1;
    cyc("bin.load", 3'b000, 3'd0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc("bin", 3'(i), 3'(i), 1'b1, 1'b0);
      if (i == 3) begin start = 1'b1; mode = 2'b10; hold_cycles = 4'd5; end
      if (i == 4) start = 1'b0;
    end
    cyc("bin.done", 3'b000, 3'd0, 1'b0, 1'b1);
    cyc("bin.idle", 3'b000, 3'd0, 1'b0, 1'b0);

    // Gray, hold 3 cycles per vector, single-bit changes
    mode = 2'b01; loop = 1'b0; hold_cycles = 4'd2; start = 1'b1;
    cyc("gray.load", 3'b000, 3'd0, 1'b1, 1'b0);
    start = 1'b0;
    obs_prev = 3'b000;
    for (int v = 0; v < 8; v++)
      for (int k = 0; k < 3; k++) begin
        cyc("gray", gray_tab[v], 3'(v), 1'b1, 1'b0);
        if ({x, y, z} != obs_prev)
          chk("gray.onebit", $countones({x, y, z} ^ obs_prev), 32'd1);
        obs_prev = {x, y, z};
      end
    cyc("gray.done", 3'b000, 3'd0, 1'b0, 1'b1);
    cyc("gray.idle", 3'b000, 3'd0, 1'b0, 1'b0);

    // walking-one, looping, hold 2 cycles, then abort
    mode = 2'b10; loop = 1'b1; hold_cycles = 4'd1; start = 1'b1;
    cyc("walk.load", 3'b000, 3'd0, 1'b1, 1'b0);
    start = 1'b0;
    for (int c = 0; c < 14; c++)
      cyc("walk", walk_tab[(c / 2) % 3], 3'((c / 2) % 3), 1'b1, 1'b0);
    abort = 1'b1;
    cyc("walk.abort", 3'b000, 3'd0, 1'b0, 1'b0);
    abort = 1'b0;
    cyc("walk.idle", 3'b000, 3'd0, 1'b0, 1'b0);

    // start and abort together in IDLE: nothing happens
    mode = 2'b00; loop = 1'b0; hold_cycles = 4'd0;
    start = 1'b1; abort = 1'b1;
    cyc("sa", 3'b000, 3'd0, 1'b0, 1'b0);
    start = 1'b0; abort = 1'b0;
    cyc("sa.idle", 3'b000, 3'd0, 1'b0, 1'b0);

    // async reset while vector 5 is driven
    mode = 2'b00; loop = 1'b0; hold_cycles = 4'd3; start = 1'b1;
    cyc("rs.load", 3'b000, 3'd0, 1'b1, 1'b0);
    start = 1'b0;
    for (int v = 0; v < 5; v++)
      for (int k = 0; k < 4; k++) cyc("rs", 3'(v), 3'(v), 1'b1, 1'b0);
    cyc("rs.v5", 3'd5, 3'd5, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("rs.async.xyz",  {29'd0, x, y, z}, 32'd0);
    chk("rs.async.vec",  {29'd0, vec_idx}, 32'd0);
    chk("rs.async.busy", {31'd0, busy}, 32'd0);
    chk("rs.async.any",  {31'd0, any_hi}, 32'd0);
    exp_prev = 3'b000;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) cyc("rs.after", 3'b000, 3'd0, 1'b0, 1'b0);

    // mode 11 acts as binary; 16 cycles per vector at maximum hold
    mode = 2'b11; loop = 1'b0; hold_cycles = 4'd15; start = 1'b1;
    cyc("m3.load", 3'b000, 3'd0, 1'b1, 1'b0);
    start = 1'b0;
    for (int c = 0; c < 128; c++)
      cyc("m3", 3'(c / 16), 3'(c / 16), 1'b1, 1'b0);
    cyc("m3.done", 3'b000, 3'd0, 1'b0, 1'b1);
    cyc("m3.idle", 3'b000, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
